pix_addr_align: RTL and testbench

Parametrised alignment stage for the pixel-processing path. It delays the incoming pixel pair by a short fixed depth into the processing core, and delays the ZBT write address plus a valid flag through a RAM-based circular buffer so they line up with the core's processed output. Unlike the earlier shift-register scheme, the depth, the widths and the latency are all parameters. Latency can also be reprogrammed at run time, and an output-valid qualifier is provided. It sits between the video front end and the ZBT bank-1 writer.

---
 rtl/pix_align_pkg.sv | 28 ++
 rtl/align_dpram.sv | 31 +++
 rtl/pix_addr_align.sv | 177 +++++++++++++++++
 tb/tb_pix_addr_align.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pix_align_pkg.sv
`default_nettype none
// ============================================================================
// Package : pix_align_pkg
// Brief   : Shared types and constants for the pixel/address alignment stage.
// Rev     : 1.0  initial release
// ============================================================================
package pix_align_pkg;

    localparam int PIX_PAIR_W     = 36;
    localparam int DEF_ADDR_DELAY = 2 + 3 * 91;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RELOAD = 2'd2
    } align_state_e;

    function automatic int clamp_delay(input int req, input int lo, input int hi);
        if (req < lo) begin
            return lo;
        end else if (req > hi) begin
            return hi;
        end
        return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/align_dpram.sv
`default_nettype none
// ============================================================================
// Module : align_dpram
// Brief  : Simple dual-port RAM, one write port and one registered read port.
// Rev    : 1.0  initial release
// ============================================================================
module align_dpram #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 20,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on storage or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/pix_addr_align.sv
`default_nettype none
// ============================================================================
// Module : pix_addr_align
// Brief  : Delays pixel pairs into the core and aligns ZBT write address/valid
//          to the core output via a circular RAM buffer.
// Build  : define ALIGN_LAT_ADJ_EN to add run-time latency reprogramming.
// Rev    : 1.0  initial release
// ============================================================================
module pix_addr_align
    import pix_align_pkg::*;
#(
    parameter int DATA_W     = PIX_PAIR_W,
    parameter int ADDR_W     = 19,
    parameter int DATA_DELAY = 2,
    parameter int ADDR_DELAY = DEF_ADDR_DELAY,
    parameter int MAX_DELAY  = 512
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              pix_in,
    input  logic [ADDR_W-1:0]              addr_in,
    output logic [DATA_W-1:0]              pix_dly,
    input  logic [DATA_W-1:0]              proc_pix,
`ifdef ALIGN_LAT_ADJ_EN
    input  logic [$clog2(MAX_DELAY):0]     lat_sel,
    input  logic                           lat_load,
`endif
    output logic [DATA_W-1:0]              out_pix,
    output logic [ADDR_W-1:0]              out_addr,
    output logic                           out_valid,
    output logic                           primed
);

    localparam int PTR_W = $clog2(MAX_DELAY);
    localparam int DLY_W = PTR_W + 1;

    logic [DATA_W-1:0] pix_sr [DATA_DELAY];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DLY_W-1:0]  cur_delay;
    logic [DLY_W-1:0]  fill_cnt;
    logic [ADDR_W:0]   ram_wdata;
    logic [ADDR_W:0]   ram_rdata;
    align_state_e      state;
    align_state_e      state_nxt;
    logic              cnt_restart;
    logic              run_gate;

    // ------------------------------------------------------------------
    // Pixel data path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DATA_DELAY; i++) begin
                pix_sr[i] <= '0;
            end
        end else begin
            pix_sr[0] <= pix_in;
            for (int i = 1; i < DATA_DELAY; i++) begin
                pix_sr[i] <= pix_sr[i-1];
            end
        end
    end

    assign pix_dly = pix_sr[DATA_DELAY-1];

    // ------------------------------------------------------------------
    // Address path pointers
    // ------------------------------------------------------------------
    // rd_ptr is itself registered, so together with the RAM read register
    // and out_addr the path is exactly cur_delay cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= wr_ptr + PTR_W'(2) - cur_delay[PTR_W-1:0];
        end
    end

    assign ram_wdata = {in_valid, addr_in};

    align_dpram #(
        .DEPTH  (MAX_DELAY),
        .WIDTH  (ADDR_W + 1),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (1'b1),
        .waddr (wr_ptr),
        .wdata (ram_wdata),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Latency selection
    // ------------------------------------------------------------------
`ifdef ALIGN_LAT_ADJ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_delay <= DLY_W'(ADDR_DELAY);
        end else if (lat_load) begin
            cur_delay <= DLY_W'(clamp_delay(int'(lat_sel), 2, MAX_DELAY));
        end
    end
`else
    assign cur_delay = DLY_W'(ADDR_DELAY);
`endif

    // ------------------------------------------------------------------
    // Fill / run control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_restart) begin
                fill_cnt <= '0;
            end else if (state != ST_RUN) begin
                fill_cnt <= fill_cnt + DLY_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_restart = 1'b0;
        case (state)
            ST_FILL, ST_RELOAD: begin
                if (fill_cnt == cur_delay - DLY_W'(1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_FILL;
            end
        endcase
`ifdef ALIGN_LAT_ADJ_EN
        // A load in any state restarts the count against the new latency.
        if (lat_load) begin
            state_nxt   = ST_RELOAD;
            cnt_restart = 1'b1;
        end
`endif
    end

    always_comb begin
        run_gate = (state == ST_RUN);
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_pix   <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
        end else begin
            out_pix   <= proc_pix;
            out_addr  <= ram_rdata[ADDR_W-1:0];
            out_valid <= run_gate & ram_rdata[ADDR_W];
            primed    <= run_gate;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pix_addr_align.sv
`default_nettype none
// ============================================================================
// Module : tb_pix_addr_align
// Brief  : Self-checking bench for pix_addr_align against a history-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pix_addr_align;

    localparam int DATA_W     = 36;
    localparam int ADDR_W     = 19;
    localparam int DATA_DELAY = 2;
    localparam int ADDR_DELAY = 275;
    localparam int MAX_DELAY  = 512;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] pix_in   = '0;
    logic [DATA_W-1:0] proc_pix = '0;
    logic [ADDR_W-1:0] addr_in  = '0;
`ifdef ALIGN_LAT_ADJ_EN
    logic [9:0]        lat_sel  = '0;
    logic              lat_load = 1'b0;
`endif
    logic [DATA_W-1:0] pix_dly;
    logic [DATA_W-1:0] out_pix;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              primed;

    int tests = 0;
    int fails = 0;

    // Reference model: per-edge input history since the last reset release.
    int                e;
    int                dcur;
    int                run_from;
    logic [ADDR_W-1:0] a_q [$];
    logic              v_q [$];
    logic [DATA_W-1:0] p_q [$];

    pix_addr_align #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DATA_DELAY (DATA_DELAY),
        .ADDR_DELAY (ADDR_DELAY),
        .MAX_DELAY  (MAX_DELAY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .pix_in    (pix_in),
        .addr_in   (addr_in),
        .pix_dly   (pix_dly),
        .proc_pix  (proc_pix),
`ifdef ALIGN_LAT_ADJ_EN
        .lat_sel   (lat_sel),
        .lat_load  (lat_load),
`endif
        .out_pix   (out_pix),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, e, got, exp);
        end
    endtask

    task automatic rnd_inputs();
        in_valid = 1'($urandom_range(0, 1));
        addr_in  = ADDR_W'($urandom);
        pix_in   = DATA_W'({$urandom, $urandom});
        proc_pix = DATA_W'({$urandom, $urandom});
    endtask

    task automatic tick();
        logic [DATA_W-1:0] proc_s;
        logic              prim;
`ifdef ALIGN_LAT_ADJ_EN
        logic              ld_s;
        int                sel_s;
`endif
        @(posedge clk);
        a_q.push_back(addr_in);
        v_q.push_back(in_valid);
        p_q.push_back(pix_in);
        proc_s = proc_pix;
`ifdef ALIGN_LAT_ADJ_EN
        ld_s  = lat_load;
        sel_s = int'(lat_sel);
`endif
        #1;
        prim = (e >= run_from);
        chk("pix_dly", 64'(pix_dly),
            (e >= DATA_DELAY - 1) ? 64'(p_q[e - (DATA_DELAY - 1)]) : 64'd0);
        chk("out_pix", 64'(out_pix), 64'(proc_s));
        chk("primed", 64'(primed), 64'(prim));
        chk("out_valid", 64'(out_valid), prim ? 64'(v_q[e - dcur]) : 64'd0);
        if (prim) begin
            chk("out_addr", 64'(out_addr), 64'(a_q[e - dcur]));
        end
`ifdef ALIGN_LAT_ADJ_EN
        if (ld_s) begin
            dcur     = (sel_s < 2) ? 2 : ((sel_s > MAX_DELAY) ? MAX_DELAY : sel_s);
            run_from = e + 1 + dcur;
        end
`endif
        e++;
    endtask

    task automatic apply_reset(input int offs);
        #(offs);
        reset = 1'b1;
        #1;
        chk("rst_pix_dly", 64'(pix_dly), 64'd0);
        chk("rst_out_pix", 64'(out_pix), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_primed", 64'(primed), 64'd0);
        in_valid = 1'b0;
        addr_in  = '0;
        pix_in   = '0;
        proc_pix = '0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        a_q.delete();
        v_q.delete();
        p_q.delete();
        e        = 0;
        dcur     = ADDR_DELAY;
        run_from = ADDR_DELAY;
    endtask

    initial begin
        apply_reset(1);

        // Incrementing addresses from reset, with an isolated pixel marker.
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            addr_in  = ADDR_W'(i);
            pix_in   = (i == 20) ? 36'h123456789 : '0;
            proc_pix = DATA_W'({$urandom, $urandom});
            tick();
        end

        // Valid pattern 1,0,1 with addresses 10,11,12, then flush through.
        for (int i = 0; i < 3; i++) begin
            rnd_inputs();
            in_valid = (i != 1);
            addr_in  = ADDR_W'(10 + i);
            tick();
        end
        for (int i = 0; i < 280; i++) begin
            rnd_inputs();
            tick();
        end

`ifdef ALIGN_LAT_ADJ_EN
        // Reload to 5, then 0 (clamps to 2), 1000 (clamps to MAX), then
        // back-to-back loads while still reloading.
        rnd_inputs(); lat_sel = 10'd5; lat_load = 1'b1; tick(); lat_load = 1'b0;
        for (int i = 0; i < 30; i++) begin rnd_inputs(); tick(); end
        rnd_inputs(); lat_sel = 10'd0; lat_load = 1'b1; tick(); lat_load = 1'b0;
        for (int i = 0; i < 20; i++) begin rnd_inputs(); tick(); end
        rnd_inputs(); lat_sel = 10'd1000; lat_load = 1'b1; tick(); lat_load = 1'b0;
        for (int i = 0; i < 600; i++) begin rnd_inputs(); tick(); end
        rnd_inputs(); lat_sel = 10'd300; lat_load = 1'b1; tick(); lat_load = 1'b0;
        for (int i = 0; i < 10; i++) begin rnd_inputs(); tick(); end
        rnd_inputs(); lat_sel = 10'd7; lat_load = 1'b1; tick(); lat_load = 1'b0;
        for (int i = 0; i < 40; i++) begin rnd_inputs(); tick(); end
`endif

        // Asynchronous reset at a non-clock instant mid-stream.
        for (int i = 0; i < 50; i++) begin rnd_inputs(); tick(); end
        apply_reset($urandom_range(1, 3));

        // Long run across several pointer wraps with sequential addresses.
        for (int i = 0; i < ADDR_DELAY + 3 * MAX_DELAY; i++) begin
            rnd_inputs();
            addr_in = ADDR_W'(i + 1000);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
